// File: rtl/capture_sequencer.sv
// capture_sequencer: burst ADC capture into a small buffer, drained
// oldest-first to the serial TX, followed by a hold-off before re-arm.
// Ports: clk, rst (async, active-low); start, auto_rearm, burst_len arm;
// adc_valid, adc_sample capture; tx_busy, tx_start, tx_data TX handshake;
// busy, done, tx_err, sample_cnt status.
module capture_sequencer #(
  parameter int DEPTH          = 16,
  parameter int HOLDOFF_CYCLES = 500000,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_rearm,
  input  logic [4:0]  burst_len,
  input  logic        adc_valid,
  input  logic [11:0] adc_sample,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [11:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        tx_err,
  output logic [4:0]  sample_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0] MAXLEN = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_HOLDOFF
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_len, r_cnt, r_sent, w_len;
  logic [AW-1:0] r_wr, r_rd;
  logic [11:0]   r_buf [DEPTH];
  logic [11:0]   r_tx_data;
  logic          r_tx_start, r_done, r_err;
  logic [TW-1:0] r_to;
  logic [HW-1:0] r_hold;
  logic          w_arm, w_wr, w_issue, w_to, w_word, w_fin;
  logic          w_hold_tc, w_to_tc;

  assign w_hold_tc = (r_hold == HW'(HOLDOFF_CYCLES - 1));
  assign w_to_tc   = (r_to == TW'(ACK_TIMEOUT - 1));

  // 0 means a single sample; anything past the buffer saturates
  always_comb begin
    w_len = burst_len;
    if (burst_len == 5'd0)
      w_len = 5'd1;
    else if (burst_len > MAXLEN)
      w_len = MAXLEN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_wr        = 1'b0;
    w_issue     = 1'b0;
    w_to        = 1'b0;
    w_word      = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_arm       = 1'b1;
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          w_wr = 1'b1;
          if (r_cnt + 5'd1 == r_len)
            w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!tx_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (tx_busy)
          w_state_nxt = S_WAIT_FALL;
        else if (w_to_tc) begin
          // no ack from TX: flag it, count the word as sent
          w_to   = 1'b1;
          w_word = 1'b1;
        end
      end
      S_WAIT_FALL: begin
        if (!tx_busy)
          w_word = 1'b1;
      end
      S_HOLDOFF: begin
        if (w_hold_tc) begin
          if (auto_rearm) begin
            w_arm       = 1'b1;
            w_state_nxt = S_CAPTURE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_word) begin
      if (r_sent < r_len)
        w_state_nxt = S_ISSUE;
      else begin
        w_fin       = 1'b1;
        w_state_nxt = S_HOLDOFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= 5'd1;
      r_cnt      <= '0;
      r_sent     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_to       <= '0;
      r_hold     <= '0;
    end else begin
      r_tx_start <= w_issue;
      r_done     <= w_fin;
      if (w_arm) begin
        r_len  <= w_len;
        r_cnt  <= '0;
        r_sent <= '0;
        r_wr   <= '0;
        r_rd   <= '0;
        r_err  <= 1'b0;
      end
      if (w_wr) begin
        r_wr  <= r_wr + AW'(1);
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_issue) begin
        r_tx_data <= r_buf[r_rd];
        r_rd      <= r_rd + AW'(1);
        r_sent    <= r_sent + 5'd1;
        r_to      <= '0;
      end else if (r_state == S_WAIT_RISE && !tx_busy) begin
        r_to <= r_to + TW'(1);
      end
      if (w_to)
        r_err <= 1'b1;
      if (r_state == S_HOLDOFF && !w_hold_tc)
        r_hold <= r_hold + HW'(1);
      else
        r_hold <= '0;
    end
  end

  // sample storage carries no reset value
  always_ff @(posedge clk) begin
    if (w_wr)
      r_buf[r_wr] <= adc_sample;
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign tx_err     = r_err;
  assign sample_cnt = r_cnt;

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Burst acquisition controller between the ADC reader and the Arduino serial writer. It arms on a start pulse or auto-rearm, captures a programmable number of 12-bit ADC samples into an internal buffer, then drains them oldest-first to the transmitter one word per transmit handshake. It enforces a hold-off between bursts so the Arduino side has time to consume each burst.

## Interface
- DEPTH, 16: buffer depth in samples, and the maximum burst length.
- HOLDOFF_CYCLES, 500000: idle cycles after a burst completes (10 ms at 50 MHz).
- ACK_TIMEOUT, 16: cycles allowed for tx_busy to rise after tx_start.
- clk  in  1  50 MHz system clock.
- rst  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  one-cycle arm request; honoured only in IDLE.
- auto_rearm  in  1  when high, HOLDOFF exits directly into a new CAPTURE.
- burst_len  in  5  samples per burst, latched on arm; 0 is treated as 1, values above 16 as 16.
- adc_valid  in  1  one-cycle strobe marking adc_sample valid.
- adc_sample  in  12  ADC conversion result.
- tx_busy  in  1  transmitter shifting a word.
- tx_start  out  1  one-cycle pulse launching transmission of tx_data.
- tx_data  out  12  word to transmit; held until the next tx_start.
- busy  out  1  high in CAPTURE, DRAIN and HOLDOFF.
- done  out  1  one-cycle pulse when the last word of a burst finishes.
- tx_err  out  1  sticky flag, ACK timeout occurred; cleared only by rst or the next arm.
- sample_cnt  out  5  samples captured in the current burst.

## Operation
- States: IDLE, CAPTURE, DRAIN (sub-phases ISSUE, WAIT_RISE, WAIT_FALL), HOLDOFF.
- IDLE:
  - On start=1: latch the clamped burst_len into len_q, clear sample_cnt, read/write pointers and tx_err, then go to CAPTURE.
- CAPTURE:
  - Each adc_valid writes adc_sample to buf[wr_ptr], then wr_ptr+1 and sample_cnt+1.
  - On the write that makes sample_cnt == len_q, go to DRAIN/ISSUE on the same edge.
  - start is ignored.
- DRAIN/ISSUE:
  - If tx_busy=0: tx_data<=buf[rd_ptr], tx_start=1 for one cycle, rd_ptr+1, go to WAIT_RISE.
  - If tx_busy=1: stall.
- WAIT_RISE:
  - If tx_busy=1: go to WAIT_FALL.
  - If ACK_TIMEOUT cycles elapse without tx_busy=1: set tx_err and treat the word as sent (same exit as a fall).
- WAIT_FALL:
  - On tx_busy=0, if words sent < len_q: return to ISSUE.
  - Otherwise: pulse done and go to HOLDOFF.
- HOLDOFF:
  - Count HOLDOFF_CYCLES.
  - At terminal count: if auto_rearm=1, re-arm as from IDLE with the current burst_len, sampled at that edge; otherwise go to IDLE.
- Ignored inputs:
  - adc_valid outside CAPTURE.
  - start outside IDLE.
  - burst_len changes after the arm.
- Pointers are 4 bits wide and wrap modulo 16; a full 16-sample burst fills the buffer exactly, with no overflow possible.
- The buffer is not cleared by reset; the buffer contents have no reset value.

## Timing
- Reset values: tx_start=0, tx_data=0, busy=0, done=0, tx_err=0, sample_cnt=0, state IDLE, holdoff counter 0. Reset asserted mid-burst aborts immediately, with no done pulse.
- Arm latency: start high at edge k, so busy=1 and the state is CAPTURE after edge k.
- Capture latency: adc_valid at edge n, so sample_cnt updates after edge n.
- Drain latency: the last sample written at edge n gives the first tx_start high in the cycle after edge n+1 (ISSUE evaluates tx_busy), if tx_busy=0.
- tx_start and tx_data are registered together, so tx_data is stable on the cycle tx_start is high.
- done is high for the cycle after the edge that sees the final tx_busy fall or timeout. busy stays 1 through HOLDOFF and drops exactly HOLDOFF_CYCLES cycles after done.
- Simultaneous adc_valid and start in IDLE: the sample is not captured.
- tx_busy already high on entry to ISSUE: no tx_start until it falls.

## Test plan
- Arm with burst_len=3, then feed samples 0x111, 0x222, 0x333 with a model transmitter (busy 40 cycles, 2 cycles after tx_start) -> three tx_start pulses carrying 0x111, 0x222, 0x333 in order, a single done, busy low HOLDOFF_CYCLES after done.
- burst_len=0 and burst_len=31 -> one sample and sixteen samples transmitted respectively; the 16-sample burst returns 16 words in FIFO order with no loss.
- Transmitter never raises busy -> each word advances after ACK_TIMEOUT=16 cycles, tx_err=1 sticks, done still pulses; the next arm clears tx_err.
- start and adc_valid pulsed during CAPTURE and DRAIN, and adc_valid in HOLDOFF -> no re-arm, sample_cnt unchanged by extra strobes, output stream identical.
- auto_rearm=1 with burst_len=2 -> after HOLDOFF a second burst captures without start; changing burst_len mid-burst affects only the next burst.
- rst asserted while in WAIT_FALL of word 2 -> all outputs reach reset values asynchronously, no done; after release a fresh start runs a clean burst.
